// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter among NUM_REQ byte requesters. Each frame it
//   grants one requester, captures its byte, pulses tx_start for one cycle and
//   holds tx_data stable for the whole frame plus GUARD idle cycles. The
//   transmitter has no busy output, so frame occupancy is counted here.
//
//   Configuration macro: UART_TX_ARB_FIXED_PRIO_EN
//     undefined : round-robin arbitration (default)
//     defined   : fixed priority, lowest valid index wins, no pointer register
//
// Ports
//   clk        in   clock
//   RSTn       in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ]    per-requester byte valid
//   req_data   in   [8*NUM_REQ]  byte of requester i on bits [8i+7:8i]
//   req_ready  out  [NUM_REQ]    one-hot accept strobe
//   tx_start   out  1            one-cycle start pulse to the transmitter
//   tx_data    out  8            byte to the transmitter
//   busy       out  1            high whenever the FSM is not idle
//   grant_id   out  [ID_W]       index of the last granted requester
//   dbg_state  out  2            current FSM state (0 idle, 1 launch, 2 wait, 3 guard)
//
// Handshake: a requester holds req_valid/req_data until it sees req_ready high;
// req_ready is combinational in the idle cycle and the byte is consumed on that
// clock edge. Dropping req_valid before acceptance withdraws the request.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DIVISOR = 10,
  parameter int GUARD   = 2,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   RSTn,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  output logic                   busy,
  output logic [ID_W-1:0]        grant_id,
  output logic [1:0]             dbg_state
);

  // Start-bit delay + start bit + 8 data bits + stop bit.
  localparam logic [31:0] FRAME_LAST = 32'(11 * DIVISOR - 1);
  localparam logic [31:0] GUARD_LAST = (GUARD > 0) ? 32'(GUARD - 1) : 32'd0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_GUARD  = 2'd3
  } state_t;

  state_t            r_state;
  logic [7:0]        r_tx_data;
  logic [ID_W-1:0]   r_grant_id;
  logic [31:0]       r_wait_cnt;
  logic [31:0]       r_guard_cnt;

  logic              w_found;
  logic [ID_W-1:0]   w_winner;
  logic [ID_W-1:0]   w_idx;
  logic [7:0]        w_byte;
  logic [NUM_REQ-1:0] w_ready;

`ifndef UART_TX_ARB_FIXED_PRIO_EN
  localparam int SUM_W = ID_W + 1;
  logic [ID_W-1:0]   r_ptr;
  logic [SUM_W-1:0]  w_sum;
`endif

  // Winner search: the first valid index starting at the pointer (or at 0
  // in fixed-priority mode). The sum is one bit wider so the wrap subtract
  // works for non-power-of-two NUM_REQ.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
    w_sum    = '0;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
      w_idx = ID_W'(k);
`else
      w_sum = {1'b0, r_ptr} + SUM_W'(k);
      if (w_sum >= SUM_W'(NUM_REQ)) begin
        w_sum = w_sum - SUM_W'(NUM_REQ);
      end
      w_idx = w_sum[ID_W-1:0];
`endif
      if (!w_found && req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    w_byte = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_winner == ID_W'(j)) begin
        w_byte = req_data[j*8 +: 8];
      end
    end
  end

  // Gated by RSTn so no requester sees an accept while reset is held.
  always_comb begin
    w_ready = '0;
    if (RSTn && (r_state == S_IDLE) && w_found) begin
      w_ready[w_winner] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_state     <= S_IDLE;
      r_tx_data   <= '0;
      r_grant_id  <= '0;
      r_wait_cnt  <= '0;
      r_guard_cnt <= '0;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
      r_ptr       <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_tx_data  <= w_byte;
            r_grant_id <= w_winner;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
            if (w_winner == ID_W'(NUM_REQ - 1)) begin
              r_ptr <= '0;
            end else begin
              r_ptr <= w_winner + 1'b1;
            end
`endif
            r_state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_wait_cnt <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wait_cnt == FRAME_LAST) begin
            r_wait_cnt <= '0;
            if (GUARD == 0) begin
              r_state <= S_IDLE;
            end else begin
              r_guard_cnt <= '0;
              r_state     <= S_GUARD;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + 32'd1;
          end
        end
        S_GUARD: begin
          if (r_guard_cnt == GUARD_LAST) begin
            r_guard_cnt <= '0;
            r_state     <= S_IDLE;
          end else begin
            r_guard_cnt <= r_guard_cnt + 32'd1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_tx_data   <= '0;
          r_grant_id  <= '0;
          r_wait_cnt  <= '0;
          r_guard_cnt <= '0;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
          r_ptr       <= '0;
`endif
        end
      endcase
    end
  end

  // tx_start comes straight from the state register, so it cannot glitch.
  assign tx_start  = (r_state == S_LAUNCH);
  assign busy      = (r_state != S_IDLE);
  assign tx_data   = r_tx_data;
  assign grant_id  = r_grant_id;
  assign req_ready = w_ready;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int DIVISOR      = 10;
  localparam int GUARD        = 2;
  localparam int FRAME_CYCLES = 11 * DIVISOR;
  localparam int SPACING      = 2 + FRAME_CYCLES + GUARD;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        RSTn = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic [1:0]  grant_id;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DIVISOR(DIVISOR), .GUARD(GUARD)) dut (
    .clk       (clk),
    .RSTn      (RSTn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .busy      (busy),
    .grant_id  (grant_id),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] d, input logic [1:0] i);
    return d[i*8 +: 8];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_grant(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * SPACING; i++) begin
      @(negedge clk);
      if (req_ready != 4'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("grant_timeout", 32'd0, 32'd1);
  endtask

  // Returns at the LAUNCH-cycle negedge of the last grant.
  task automatic run_grants(input int n);
    logic       ok;
    int         last;
    logic [1:0] e;
    last = -1;
    for (int g = 0; g < n; g++) begin
      wait_grant(ok);
      if (!ok) return;
      e = exp_q.pop_front();
      check("grant_ready", 32'(req_ready), 32'(4'b0001 << e));
      if (last >= 0) check("grant_spacing", 32'(cyc - last), 32'(SPACING));
      last = cyc;
      @(negedge clk);
      check("launch_start", 32'(tx_start), 32'd1);
      check("launch_id", 32'(grant_id), 32'(e));
      check("launch_data", 32'(tx_data), 32'(byte_of(req_data, e)));
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2 * SPACING && busy; i++) @(negedge clk);
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [1:0]  id_rr;   // expected winner, round-robin
    logic [1:0]  id_fp;   // expected winner, fixed priority
  } vec_t;

  vec_t vecs[9];

  initial begin : main
    logic [1:0] e;
    logic [7:0] eb;
    int         n_busy;
    logic       stable;
    logic       extra_start;

    vecs[0] = '{4'b0001, 32'h0000_00A5, 2'd0, 2'd0};
    vecs[1] = '{4'b1111, 32'h4433_2211, 2'd1, 2'd0};
    vecs[2] = '{4'b0001, 32'h0000_005A, 2'd0, 2'd0};
    vecs[3] = '{4'b1001, 32'h3C00_00C3, 2'd3, 2'd0};
    vecs[4] = '{4'b1001, 32'h7E00_0081, 2'd0, 2'd0};
    vecs[5] = '{4'b0100, 32'h0099_0000, 2'd2, 2'd2};
    vecs[6] = '{4'b1100, 32'hF00F_0000, 2'd3, 2'd2};
    vecs[7] = '{4'b1100, 32'h1234_0000, 2'd2, 2'd2};
    vecs[8] = '{4'b1111, 32'hDEAD_BEEF, 2'd3, 2'd0};

    // Reset held with every requester asserting.
    RSTn      = 1'b0;
    req_valid = 4'hF;
    req_data  = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_start", 32'(tx_start), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    req_valid = 4'h0;
    RSTn      = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Table: one grant per record, full frame observed.
    for (int v = 0; v < 9; v++) begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
      e = vecs[v].id_fp;
`else
      e = vecs[v].id_rr;
`endif
      eb = byte_of(vecs[v].data, e);
      @(posedge clk);
      #1;
      req_valid = vecs[v].valid;
      req_data  = vecs[v].data;
      @(negedge clk);
      check("vec_ready", 32'(req_ready), 32'(4'b0001 << e));
      @(posedge clk);
      #1;
      req_valid = 4'h0;
      @(negedge clk);
      check("vec_start", 32'(tx_start), 32'd1);
      check("vec_id", 32'(grant_id), 32'(e));
      check("vec_data", 32'(tx_data), 32'(eb));
      check("vec_busy", 32'(busy), 32'd1);
      n_busy      = 1;
      stable      = 1'b1;
      extra_start = 1'b0;
      while (busy && n_busy < 3 * SPACING) begin
        @(negedge clk);
        if (busy) begin
          n_busy++;
          if (tx_start) extra_start = 1'b1;
          if (tx_data !== eb) stable = 1'b0;
        end
      end
      check("vec_busy_len", 32'(n_busy), 32'(SPACING - 1));
      check("vec_data_stable", 32'(stable), 32'd1);
      check("vec_single_start", 32'(extra_start), 32'd0);
    end

    // All four held valid: grant order and exact spacing.
    @(posedge clk);
    #1;
    req_data  = 32'hD4C3_B2A1;
    req_valid = 4'hF;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    exp_q = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
    run_grants(5);
    req_valid = 4'h0;

    // Reset 50 cycles into the frame, away from a clock edge.
    repeat (49) @(negedge clk);
    #2;
    RSTn = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_start", 32'(tx_start), 32'd0);
    check("mid_rst_id", 32'(grant_id), 32'd0);
    check("mid_rst_data", 32'(tx_data), 32'd0);
    req_data  = 32'h6B00_9400;
    req_valid = 4'b1010;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    RSTn = 1'b1;
    #1;
    check("rel_ready", 32'(req_ready), 32'b0010);
    @(negedge clk);
    check("rel_start", 32'(tx_start), 32'd1);
    check("rel_id", 32'(grant_id), 32'd1);
    check("rel_data", 32'(tx_data), 32'h94);

    // Requests 1 and 3 held; then only 3.
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    exp_q = '{2'd1, 2'd1, 2'd1};
`else
    exp_q = '{2'd3, 2'd1, 2'd3};
`endif
    run_grants(3);
    req_valid = 4'b1000;
    exp_q.push_back(2'd3);
    run_grants(1);
    req_valid = 4'h0;
    wait_idle();
    check("end_state", 32'(dbg_state), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter among NUM_REQ byte requesters using round-robin arbitration.
Per frame, it grants one requester and captures its byte. It then issues a single-cycle start pulse and holds the byte stable for the whole frame plus a guard gap.
It sits between the client-facing valid/ready interfaces and the transmitter's start/data_in inputs. The transmitter provides no busy output, so frame occupancy is tracked here by cycle count.

Parameters:
NUM_REQ, 4, number of requesters (2..16).
DIVISOR, 10, clk cycles per UART bit; must match the transmitter's divisor.
GUARD, 2, idle clk cycles inserted after each frame (0 allowed: guard state skipped).

Ports:
clk  input  1  clock
RSTn  input  1  reset, asynchronous, active-low
req_valid  input  NUM_REQ  per-requester byte-valid
req_data  input  8*NUM_REQ  byte of requester i on bits [8i+7:8i]
req_ready  output  NUM_REQ  one-hot accept strobe; byte consumed this cycle
tx_start  output  1  one-cycle start pulse to transmitter
tx_data  output  8  byte to transmitter, stable for whole frame
busy  output  1  high whenever state != IDLE
grant_id  output  max(1,$clog2(NUM_REQ))  index of last granted requester

Behaviour:
- Local constant FRAME_CYCLES = 11*DIVISOR, covering start-bit delay, start bit, 8 data bits and stop bit. All counters are 32-bit unsigned.
- Reset values (asynchronous, immediate, also mid-frame):
  - state = IDLE; tx_start = 0; tx_data = 0x00; grant_id = 0.
  - Round-robin pointer = 0; wait and guard counters = 0.
  - req_ready = 0; busy = 0.
- IDLE:
  - If any req_valid is high, the winner is the first valid index searching pointer, pointer+1, … modulo NUM_REQ.
  - req_ready[winner] = 1 in this same cycle. This is combinational from req_valid and state; all other bits stay 0.
  - Also in this cycle: tx_data <= req_data[winner]; grant_id <= winner; pointer <= (winner+1) mod NUM_REQ; next state LAUNCH.
  - If no req_valid is high, stay in IDLE; all outputs hold.
- LAUNCH:
  - tx_start = 1 for exactly this cycle; it is decoded from the state register, so it is glitch-free.
  - Wait counter cleared; next state WAIT.
- WAIT:
  - Counter increments each cycle. At FRAME_CYCLES-1, go to GUARD, or to IDLE if GUARD == 0.
  - req_valid is ignored; req_ready stays 0.
- GUARD:
  - Counter increments each cycle. At GUARD-1, go to IDLE.
- Timing:
  - Back-to-back grant spacing = 2 + FRAME_CYCLES + GUARD cycles (114 with defaults).
  - tx_data changes only in the IDLE grant cycle, so it is stable from LAUNCH through end of GUARD.
- Handshake rules:
  - A requester holds req_valid and req_data until it sees req_ready.
  - Dropping req_valid before acceptance withdraws the request without error.
  - req_valid asserted during WAIT or GUARD is serviced at the next IDLE.
  - Simultaneous requests are resolved by the pointer only.
- Illegal state encodings return to IDLE with reset values.
- Transmitter shares RSTn, so a mid-frame reset aborts both blocks consistently.

Optional Feature:
Macro UART_TX_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest valid index always wins; pointer register removed.
- Undefined: round-robin as described above.
- All ports and timing are identical in both modes.

Test Plan:
- Reset: RSTn low with all req_valid high -> req_ready = 0, tx_start = 0, tx_data = 0x00, busy = 0, grant_id = 0 during reset and until the first IDLE evaluation after release.
- Single request: req_valid[0] = 1, req_data[0] = 0xA5 at cycle t:
  - req_ready[0] = 1 at t; tx_start = 1 only at t+1; tx_data = 0xA5 from t+1.
  - busy high t+1..t+113; the attached transmitter's TX line decodes 0xA5 at 10 clk/bit.
- All 4 requesters valid continuously -> grants in order 0,1,2,3,0 with req_ready pulses exactly 114 cycles apart; each tx_data equals the granted requester's byte.
- Pointer wrap: after a grant to 2 (pointer = 3), only req 2 and req 3 valid -> next grant 3, then 2.
- Reset mid-frame: RSTn low at t+50 of a frame -> busy = 0 and tx_start = 0 immediately, pointer = 0; after release, with req 1 and req 3 valid, grant 1 first.
- With UART_TX_ARB_FIXED_PRIO_EN defined: req 1 and req 3 continuously valid -> every grant goes to 1; req 3 is granted only after req_valid[1] drops.
